// File: rtl/sched_loader_if.sv
//------------------------------------------------------------------------------
// sched_loader_if : host byte link, sweep status and schedule RAM write bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sched_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic [3:0]  ram_we;
  logic [6:0]  ram_waddr;
  logic [31:0] ram_din;
  logic [6:0]  sched_length;
  logic        trigger;
  logic        err;

  modport master (
    output rx_data, rx_valid, busy,
    input  rx_ready, ram_we, ram_waddr, ram_din, sched_length, trigger, err
  );

  modport slave (
    input  rx_data, rx_valid, busy,
    output rx_ready, ram_we, ram_waddr, ram_din, sched_length, trigger, err
  );
endinterface

`default_nettype wire

// File: rtl/sched_loader.sv
//------------------------------------------------------------------------------
// sched_loader : decodes host command frames into schedule RAM writes,
//                schedule length updates and sweep trigger pulses
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sched_loader #(
  parameter int TIMEOUT = 255
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sched_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_LEN    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  c_OP_WRITE = 2'b00;
  localparam logic [1:0]  c_OP_SETLEN = 2'b01;
  localparam logic [1:0]  c_OP_FIRE = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sel;
  logic        r_is_len;
  logic [1:0]  r_idx;
  logic [15:0] r_tmo;
  logic [6:0]  r_waddr;
  logic [31:0] r_din;
  logic [6:0]  r_len_pend;
  logic [6:0]  r_len;
  logic        r_trig;
  logic        r_err;

  logic        w_rdy;
  logic        w_accept;
  logic        w_counting;
  logic        w_tmo_hit;
  logic        w_load;
  logic        w_err;
  logic        w_trig;

  assign w_rdy      = (r_state != S_COMMIT);
  assign w_accept   = bus.rx_valid && w_rdy;
  assign w_counting = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_LEN);
  assign w_tmo_hit  = w_counting && !w_accept && (r_tmo == c_TMO_LAST);

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_trig = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.rx_data[7:6])
            c_OP_WRITE:  w_next = S_ADDR;
            c_OP_SETLEN: w_next = S_LEN;
            c_OP_FIRE: begin
              if (!bus.busy && (r_len != 7'd0)) w_trig = 1'b1;
              else                               w_err  = 1'b1;
            end
            default:     w_err = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          if (bus.rx_data[7]) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_DATA;
          end
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (r_idx == 2'd3) w_next = S_COMMIT;
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          if (bus.rx_data[7] || (bus.rx_data == 8'd0)) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_COMMIT;
          end
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (!bus.busy) begin
          w_load = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 2'd0;
      r_is_len   <= 1'b0;
      r_idx      <= 2'd0;
      r_tmo      <= 16'd0;
      r_waddr    <= 7'd0;
      r_din      <= 32'd0;
      r_len_pend <= 7'd0;
      r_len      <= 7'd0;
      r_trig     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_trig <= w_trig;
      r_err  <= w_err;

      // Counter holds its value in COMMIT so busy can stall indefinitely.
      if (w_accept || (r_state == S_IDLE) || w_tmo_hit) begin
        r_tmo <= 16'd0;
      end else if (w_counting) begin
        r_tmo <= r_tmo + 16'd1;
      end

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            r_sel    <= bus.rx_data[1:0];
            r_is_len <= (bus.rx_data[7:6] == c_OP_SETLEN);
          end
          S_ADDR: begin
            if (!bus.rx_data[7]) r_waddr <= bus.rx_data[6:0];
            r_idx <= 2'd0;
          end
          S_DATA: begin
            r_din[{r_idx, 3'b000} +: 8] <= bus.rx_data;
            r_idx <= r_idx + 2'd1;
          end
          S_LEN:   r_len_pend <= bus.rx_data[6:0];
          default: ;
        endcase
      end

      if (w_load && r_is_len) r_len <= r_len_pend;
    end
  end

  // Commit outputs are combinational so they appear in the first busy-free COMMIT cycle.
  assign bus.rx_ready     = w_rdy;
  assign bus.ram_we       = (w_load && !r_is_len) ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.ram_waddr    = r_waddr;
  assign bus.ram_din      = r_din;
  assign bus.sched_length = (w_load && r_is_len) ? r_len_pend : r_len;
  assign bus.trigger      = r_trig;
  assign bus.err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sched_loader.sv
//------------------------------------------------------------------------------
// tb_sched_loader : directed frames with scoreboard of expected output pulses
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sched_loader;
  localparam int TMO = 20;

  logic clk;
  logic rst_n;

  sched_loader_if u_if ();

  sched_loader #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  we;
    logic        trig;
    logic        err;
    logic [6:0]  addr;
    logic [31:0] din;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void exp_write(logic [3:0] we, logic [6:0] a, logic [31:0] d);
    exp_t e;
    e.we = we; e.trig = 1'b0; e.err = 1'b0; e.addr = a; e.din = d;
    q.push_back(e);
  endfunction

  function automatic void exp_pulse(logic t, logic er);
    exp_t e;
    e.we = 4'b0; e.trig = t; e.err = er; e.addr = 7'd0; e.din = 32'd0;
    q.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(logic [7:0] b);
    bit done = 0;
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (u_if.rx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    u_if.rx_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every pulse cycle must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (u_if.ram_we != 4'b0 || u_if.trigger || u_if.err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got we=%b trig=%b err=%b, expected no pulse",
                 u_if.ram_we, u_if.trigger, u_if.err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (u_if.ram_we !== e.we || u_if.trigger !== e.trig || u_if.err !== e.err ||
            (e.we != 4'b0 && (u_if.ram_waddr !== e.addr || u_if.ram_din !== e.din))) begin
          errors++;
          $display("FAIL scoreboard: got we=%b trig=%b err=%b addr=%h din=%h, expected we=%b trig=%b err=%b addr=%h din=%h",
                   u_if.ram_we, u_if.trigger, u_if.err, u_if.ram_waddr, u_if.ram_din,
                   e.we, e.trig, e.err, e.addr, e.din);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    u_if.busy     = 1'b0;
    #12;
    chk("reset_ram_we", {28'd0, u_if.ram_we}, 32'd0);
    chk("reset_waddr", {25'd0, u_if.ram_waddr}, 32'd0);
    chk("reset_din", u_if.ram_din, 32'd0);
    chk("reset_len", {25'd0, u_if.sched_length}, 32'd0);
    chk("reset_trig_err", {30'd0, u_if.trigger, u_if.err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    chk("reset_rx_ready", {31'd0, u_if.rx_ready}, 32'd1);

    // FIRE with zero length
    exp_pulse(1'b0, 1'b1);
    send(8'h80);
    idle(3);

    // WRITE to tstep RAM
    exp_write(4'b0100, 7'd5, 32'hDEADBEEF);
    send(8'h02); send(8'h05); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    @(negedge clk);
    chk("write_latency_we", {28'd0, u_if.ram_we}, 32'h4);
    idle(3);

    // SETLEN 16 then FIRE
    send(8'h40); send(8'h10);
    @(negedge clk);
    chk("setlen_latency", {25'd0, u_if.sched_length}, 32'd16);
    idle(2);
    exp_pulse(1'b1, 1'b0);
    send(8'h80);
    @(negedge clk);
    chk("fire_trigger", {31'd0, u_if.trigger}, 32'd1);
    idle(3);

    // WRITE held in COMMIT by busy
    u_if.busy = 1'b1;
    exp_write(4'b0001, 7'd7, 32'h12345678);
    send(8'h00); send(8'h07); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("busy_rx_ready", {31'd0, u_if.rx_ready}, 32'd0);
      chk("busy_ram_we", {28'd0, u_if.ram_we}, 32'd0);
    end
    @(posedge clk); #1 u_if.busy = 1'b0;
    @(negedge clk);
    chk("busy_release_we", {28'd0, u_if.ram_we}, 32'h1);
    idle(3);

    // Timeout in DATA, then a clean frame
    exp_pulse(1'b0, 1'b1);
    send(8'h00); send(8'h03);
    idle(TMO + 5);
    chk("timeout_rx_ready", {31'd0, u_if.rx_ready}, 32'd1);
    exp_write(4'b1000, 7'd9, 32'h04030201);
    send(8'h03); send(8'h09); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(3);

    // Bad length and reserved opcode
    exp_pulse(1'b0, 1'b1);
    send(8'h40); send(8'h00);
    idle(2);
    exp_pulse(1'b0, 1'b1);
    send(8'hC0);
    idle(2);
    chk("len_unchanged", {25'd0, u_if.sched_length}, 32'd16);

    // Length boundaries 127 and 128
    send(8'h40); send(8'h7F);
    idle(2);
    chk("len_127", {25'd0, u_if.sched_length}, 32'd127);
    exp_pulse(1'b0, 1'b1);
    send(8'h40); send(8'h80);
    idle(2);
    chk("len_128_rejected", {25'd0, u_if.sched_length}, 32'd127);

    // Address byte with bit7 set
    exp_pulse(1'b0, 1'b1);
    send(8'h00); send(8'h85);
    idle(3);

    // Reset mid-frame
    send(8'h00); send(8'h01); send(8'hAA);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_len", {25'd0, u_if.sched_length}, 32'd0);
    chk("midreset_waddr", {25'd0, u_if.ram_waddr}, 32'd0);
    chk("midreset_din", u_if.ram_din, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(TMO + 5);
    exp_pulse(1'b0, 1'b1);
    send(8'h80);
    idle(5);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sched_loader.md
SCHED_LOADER -- requirements
Module: sched_loader

Interface
REQ-001 Parameter TIMEOUT, default 255: idle cycles allowed between bytes of one command before abort; range 1..65535.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-004 rx_data  in  8  command/payload byte from host link.
REQ-005 rx_valid  in  1  rx_data valid; byte accepted on a cycle with rx_valid=1 and rx_ready=1.
REQ-006 rx_ready  out  1  loader can accept a byte.
REQ-007 busy  in  1  frequency sweep in progress; RAM and length writes are blocked while high.
REQ-008 ram_we  out  4  one-hot write enable: bit0 freq, bit1 fstep, bit2 tstep, bit3 holdt RAM.
REQ-009 ram_waddr  out  7  shared write address for all four RAMs.
REQ-010 ram_din  out  32  shared write data for all four RAMs.
REQ-011 sched_length  out  7  number of schedule entries presented to the sweep engine.
REQ-012 trigger  out  1  one-cycle sweep start pulse.
REQ-013 err  out  1  one-cycle pulse on any protocol error or timeout.

Function
REQ-014 Command byte opcode is rx_data[7:6]: 00 WRITE (rx_data[1:0] = RAM select), 01 SETLEN, 10 FIRE, 11 reserved.
REQ-015 WRITE frame: command, address byte, then 4 data bytes LSB first; 6 bytes total.
REQ-016 SETLEN frame: command, then length byte; FIRE frame: command only.
REQ-017 States: IDLE, ADDR, DATA, LEN, COMMIT; exactly one active.
REQ-018 IDLE: accepted WRITE goes to ADDR, SETLEN to LEN, FIRE evaluated in place, reserved opcode gives err pulse and stays IDLE.
REQ-019 ADDR: accepted byte with bit7=0 latches ram_waddr and goes to DATA with byte index 0; bit7=1 gives err pulse and returns to IDLE.
REQ-020 DATA: each accepted byte shifts into ram_din[8*i+7:8*i] for byte index i; after index 3 goes to COMMIT.
REQ-021 LEN: accepted byte 1..127 is held pending and goes to COMMIT; 0 or >127 gives err pulse and returns to IDLE, sched_length unchanged.
REQ-022 COMMIT: rx_ready=0; waits while busy=1; on the first cycle with busy=0 it asserts the selected ram_we bit, or loads sched_length, for exactly one cycle, then returns to IDLE.
REQ-023 Latency: with busy=0, ram_we rises in the cycle after the 4th data byte is accepted; sched_length updates in the cycle after the length byte is accepted.
REQ-024 ram_waddr and ram_din are stable from COMMIT entry through the ram_we cycle.
REQ-025 rx_ready=1 in IDLE, ADDR, DATA and LEN; 0 in COMMIT.
REQ-026 FIRE: trigger pulses 1 cycle after acceptance when busy=0 and sched_length!=0; otherwise err pulses and trigger stays 0.
REQ-027 Timeout counter clears on each accepted byte and increments in ADDR, DATA and LEN; reaching TIMEOUT gives err pulse and returns to IDLE with no write.
REQ-028 The timeout counter is frozen in COMMIT; busy may hold COMMIT indefinitely.
REQ-029 ram_we, trigger and err are 0 on every cycle except their defined pulse cycles; at most one ram_we bit is high at a time.

Reset
REQ-030 Reset low: state IDLE, ram_we=0, ram_waddr=0, ram_din=0, sched_length=0, trigger=0, err=0, byte index and timeout counter 0; rx_ready=1 after release.
REQ-031 Reset mid-frame discards the partial frame; no RAM write or length change occurs.

Verification
REQ-032 Bytes 02,05,EF,BE,AD,DE with busy=0 -> one cycle ram_we=0100, waddr=5, din=DEADBEEF.
REQ-033 Bytes 40,10 then 80 with busy=0 -> sched_length=16, then one trigger pulse, err=0.
REQ-034 Bytes 80 after reset (sched_length=0) -> err pulse, trigger stays 0.
REQ-035 WRITE frame completed with busy=1 for 20 cycles -> rx_ready=0 and ram_we=0 throughout, ram_we pulse on the cycle after busy falls.
REQ-036 Bytes 00,03 then no byte for TIMEOUT cycles -> err pulse, IDLE; next full frame writes normally.
REQ-037 Bytes 40,00 and C0 -> err pulse each; sched_length unchanged.
